seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the team's combinational multiplier: it takes a product-side operand (dividend) and a factor (divisor), and returns quotient and remainder.
- Start/done handshake; one quotient bit resolved per clock.
- Used by lab datapaths that need division, and as a self-check partner for the multiplier (q*b + r == a).

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only when busy==0
- dividend  input  WIDTH  unsigned dividend, sampled on accepted start
- divisor  input  WIDTH  unsigned divisor, sampled on accepted start
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  registered quotient, held until next accepted start
- remainder  output  WIDTH  registered remainder, held until next accepted start
- div_by_zero  output  1  registered flag for the last operation, held with results

Behaviour:
- Reset (rst_n==0 at a rising edge):
  - state=IDLE
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0
  - iteration counter=0
  - Applies mid-operation too; the partial operation is discarded.
- States:
  - IDLE: waits for start.
  - RUN: one iteration per cycle.
  - DONE: single cycle, done=1.
- Start acceptance:
  - start is accepted at edge E0 when state is IDLE or DONE (back-to-back allowed).
  - start in RUN is ignored; operands are not re-sampled.
- Accepted start, divisor!=0:
  - At E0: load working remainder R (WIDTH+1 bits) = 0, working quotient Q = dividend, D = divisor, count = 0.
  - At E0: state=RUN, busy=1, div_by_zero=0.
  - quotient/remainder outputs keep their old values until done.
- Each RUN edge:
  - Shift {R,Q} left by 1.
  - T = R - {0,D}.
  - If T non-negative (MSB 0): R=T and Q[0]=1; else Q[0]=0.
  - count++.
- At edge E_WIDTH (count reaches WIDTH):
  - quotient=Q, remainder=R[WIDTH-1:0].
  - state=DONE, busy=0, done=1.
- At E_WIDTH+1: done=0, state=IDLE (or RUN if a new start is accepted).
- Latency: done is high WIDTH cycles after the accepting edge. Throughput: one division per WIDTH+1 cycles.
- Accepted start, divisor==0:
  - At E0: quotient=all ones, remainder=dividend, div_by_zero=1, done=1, busy=0, state=DONE.
  - Latency is 1 cycle.
- Arithmetic:
  - Purely unsigned.
  - Invariant for nonzero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.
- Input changes on dividend/divisor during RUN have no effect.
- done and busy are never both 1.

Decomposition:
- Shared package seq_divider_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH constant
- Natural sub-module: div_step, a combinational single restoring step.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Instantiated once in seq_divider and testable standalone.
- The counter and FSM stay in the top module.

Test Plan:
- Basic (WIDTH=4): dividend=13, divisor=3, start for one cycle -> busy for 4 cycles; then done=1 for exactly one cycle with quotient=4, remainder=1, div_by_zero=0. Values are held after done falls.
- Exhaustive (WIDTH=4): all 256 dividend/divisor pairs, each started after the previous done -> for divisor!=0, quotient==a/b and remainder==a%b; for divisor==0, quotient=4'b1111, remainder=dividend, div_by_zero=1, done one cycle after start. Bench counts errors and prints test and error totals.
- Ignore start while busy: start 15/2, then raise start with 9/4 two cycles later -> first done gives q=7, r=1; no second done occurs until a new start is issued in IDLE/DONE.
- Back-to-back: start 15/4, then assert start with 10/3 in the DONE cycle -> done pulses with q=3 r=3, then 5 cycles later q=3 r=1; busy rises in the cycle after the first done.
- Reset mid-run: start 14/5, drop rst_n low for one edge after 2 RUN cycles -> next cycle all outputs 0 and state IDLE; a following start 14/5 yields q=2 r=4.
- Width scaling (WIDTH=8): 255/16 -> q=15, r=15 after 8 busy cycles; 200/0 -> q=255, r=200, div_by_zero=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs_in,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // One guard bit above the shifted remainder so the trial difference carries its own sign.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_in};

    always_comb begin
        rem_out = shifted[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_out = trial[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake; one
// quotient bit per clock, divide-by-zero answered in a single cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_wk_q, rem_wk_d, rem_step;
    logic [WIDTH-1:0] quo_wk_q, quo_wk_d, quo_step;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_wk_q),
        .quo_in  (quo_wk_q),
        .dvs_in  (dvs_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // A new request is taken in IDLE and also in the DONE cycle for back-to-back use.
    assign accept = start && (state_q != ST_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_wk_d    = rem_wk_q;
        quo_wk_d    = quo_wk_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        if (accept) begin
            cnt_d = '0;
            if (divisor == '0) begin
                quotient_d  = '1;
                remainder_d = dividend;
                dbz_d       = 1'b1;
                state_d     = ST_DONE;
            end else begin
                rem_wk_d = '0;
                quo_wk_d = dividend;
                dvs_d    = divisor;
                dbz_d    = 1'b0;
                state_d  = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    rem_wk_d = rem_step;
                    quo_wk_d = quo_step;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        quotient_d  = quo_step;
                        remainder_d = rem_step[WIDTH-1:0];
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Working registers are only meaningful while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        rem_wk_q <= rem_wk_d;
        quo_wk_q <= quo_wk_d;
        dvs_q    <= dvs_d;
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=4 and WIDTH=8 against plain
// integer division.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] a4, b4, q4, r4;
    logic [7:0] a8, b8, q8, r8;
    logic       busy4, done4, z4;
    logic       busy8, done8, z8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    // Issue one operation from idle and wait (bounded) for done.
    // k = number of clock edges after the accepting edge until done is seen.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          output int k, output logic [7:0] q, output logic [7:0] r,
                          output logic z, output logic bsy);
        @(negedge clk);
        if (w8) begin start8 = 1'b1; a8 = a; b8 = b; end
        else begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        k = 0;
        while (!(w8 ? done8 : done4) && k < 60) begin
            @(negedge clk);
            k++;
        end
        q   = w8 ? q8 : {4'b0, q4};
        r   = w8 ? r8 : {4'b0, r4};
        z   = w8 ? z8 : z4;
        bsy = w8 ? busy8 : busy4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({busy4, done4, q4, r4, z4} !== 11'd0) begin
            fails++;
            $display("FAIL reset_w4: busy=%b done=%b q=%0d r=%0d dbz=%b, expected all zero",
                     busy4, done4, q4, r4, z4);
        end
        tests++;
        if ({busy8, done8, q8, r8, z8} !== 19'd0) begin
            fails++;
            $display("FAIL reset_w8: busy=%b done=%b q=%0d r=%0d dbz=%b, expected all zero",
                     busy8, done8, q8, r8, z8);
        end
    endtask

    task automatic test_basic();
        int busy_cnt;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd13; b4 = 4'd3;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy4 && !done4) busy_cnt++;
        end
        tests++;
        if (busy_cnt !== 4) begin
            fails++;
            $display("FAIL basic_busy: busy cycles=%0d, expected 4", busy_cnt);
        end
        @(negedge clk);
        tests++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || q4 !== 4'd4 || r4 !== 4'd1 || z4 !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done=%b busy=%b q=%0d r=%0d dbz=%b, expected 1 0 4 1 0",
                     done4, busy4, q4, r4, z4);
        end
        @(negedge clk);
        tests++;
        if (done4 !== 1'b0 || q4 !== 4'd4 || r4 !== 4'd1) begin
            fails++;
            $display("FAIL basic_hold: done=%b q=%0d r=%0d, expected 0 4 1", done4, q4, r4);
        end
    endtask

    task automatic test_exhaustive();
        int k, ek;
        logic [7:0] q, r, eq, er;
        logic z, ez, bsy;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1'b0, 8'(a), 8'(b), k, q, r, z, bsy);
                if (b == 0) begin eq = 8'd15; er = 8'(a); ez = 1'b1; ek = 0; end
                else begin eq = 8'(a / b); er = 8'(a % b); ez = 1'b0; ek = 4; end
                tests++;
                if (q !== eq || r !== er || z !== ez || k !== ek || bsy !== 1'b0) begin
                    fails++;
                    $display("FAIL exh_w4 %0d/%0d: q=%0d r=%0d dbz=%b lat=%0d busy=%b, expected q=%0d r=%0d dbz=%b lat=%0d busy=0",
                             a, b, q, r, z, k, bsy, eq, er, ez, ek);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int extra;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd2;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd4;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        @(negedge clk);
        tests++;
        if (done4 !== 1'b0 || busy4 !== 1'b1) begin
            fails++;
            $display("FAIL ignore_run: done=%b busy=%b, expected 0 1", done4, busy4);
        end
        @(negedge clk);
        tests++;
        if (done4 !== 1'b1 || q4 !== 4'd7 || r4 !== 4'd1 || z4 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_done: done=%b q=%0d r=%0d dbz=%b, expected 1 7 1 0",
                     done4, q4, r4, z4);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4 || busy4) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL ignore_no_second: activity cycles=%0d, expected 0", extra);
        end
    endtask

    task automatic test_random_noise();
        logic [3:0] a, b;
        int k;
        for (int n = 0; n < 20; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(1, 15));
            @(negedge clk);
            start4 = 1'b1; a4 = a; b4 = b;
            k = 0;
            @(negedge clk);
            while (!done4 && k < 60) begin
                start4 = 1'($urandom);
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                @(negedge clk);
                k++;
            end
            start4 = 1'b0;
            tests++;
            if (q4 !== a / b || r4 !== a % b || k !== 4) begin
                fails++;
                $display("FAIL noise_w4 %0d/%0d: q=%0d r=%0d lat=%0d, expected q=%0d r=%0d lat=4",
                         a, b, q4, r4, k, a / b, a % b);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k, j;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd4;
        @(negedge clk);
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 60) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (q4 !== 4'd3 || r4 !== 4'd3 || k !== 4) begin
            fails++;
            $display("FAIL b2b_first: q=%0d r=%0d lat=%0d, expected 3 3 4", q4, r4, k);
        end
        start4 = 1'b1; a4 = 4'd10; b4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        tests++;
        if (busy4 !== 1'b1 || done4 !== 1'b0 || q4 !== 4'd3 || r4 !== 4'd3) begin
            fails++;
            $display("FAIL b2b_rise: busy=%b done=%b q=%0d r=%0d, expected 1 0 3 3",
                     busy4, done4, q4, r4);
        end
        j = 1;
        while (!done4 && j < 60) begin
            @(negedge clk);
            j++;
        end
        tests++;
        if (q4 !== 4'd3 || r4 !== 4'd1 || j !== 5) begin
            fails++;
            $display("FAIL b2b_second: q=%0d r=%0d gap=%0d, expected 3 1 5", q4, r4, j);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        logic [7:0] q, r;
        logic z, bsy;
        run_op(1'b0, 8'd7, 8'd0, k, q, r, z, bsy);
        tests++;
        if (q !== 8'd15 || r !== 8'd7 || z !== 1'b1 || k !== 0) begin
            fails++;
            $display("FAIL dbz_w4: q=%0d r=%0d dbz=%b lat=%0d, expected 15 7 1 0", q, r, z, k);
        end
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd14; b4 = 4'd5;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({busy4, done4, q4, r4, z4} !== 11'd0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b done=%b q=%0d r=%0d dbz=%b, expected all zero",
                     busy4, done4, q4, r4, z4);
        end
        repeat (6) @(negedge clk);
        tests++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            fails++;
            $display("FAIL midrun_quiet: busy=%b done=%b, expected 0 0", busy4, done4);
        end
        run_op(1'b0, 8'd14, 8'd5, k, q, r, z, bsy);
        tests++;
        if (q !== 8'd2 || r !== 8'd4 || z !== 1'b0 || k !== 4) begin
            fails++;
            $display("FAIL midrun_retry: q=%0d r=%0d dbz=%b lat=%0d, expected 2 4 0 4", q, r, z, k);
        end
    endtask

    task automatic test_width8();
        int k, ek;
        logic [7:0] q, r, a, b, eq, er;
        logic z, ez, bsy;
        run_op(1'b1, 8'd255, 8'd16, k, q, r, z, bsy);
        tests++;
        if (q !== 8'd15 || r !== 8'd15 || z !== 1'b0 || k !== 8) begin
            fails++;
            $display("FAIL w8_255_16: q=%0d r=%0d dbz=%b lat=%0d, expected 15 15 0 8", q, r, z, k);
        end
        run_op(1'b1, 8'd200, 8'd0, k, q, r, z, bsy);
        tests++;
        if (q !== 8'd255 || r !== 8'd200 || z !== 1'b1 || k !== 0) begin
            fails++;
            $display("FAIL w8_200_0: q=%0d r=%0d dbz=%b lat=%0d, expected 255 200 1 0", q, r, z, k);
        end
        for (int n = 0; n < 150; n++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(1'b1, a, b, k, q, r, z, bsy);
            if (b == 0) begin eq = 8'd255; er = a; ez = 1'b1; ek = 0; end
            else begin eq = a / b; er = a % b; ez = 1'b0; ek = 8; end
            tests++;
            if (q !== eq || r !== er || z !== ez || k !== ek || bsy !== 1'b0) begin
                fails++;
                $display("FAIL rand_w8 %0d/%0d: q=%0d r=%0d dbz=%b lat=%0d busy=%b, expected q=%0d r=%0d dbz=%b lat=%0d busy=0",
                         a, b, q, r, z, k, bsy, eq, er, ez, ek);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive();
        test_ignore_start();
        test_random_noise();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
